// File: rtl/sdram_cmd_issuer_pkg.sv
// ============================================================================
// sdram_cmd_issuer_pkg : shared state encodings and widths for the issuer
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

package sdram_cmd_issuer_pkg;

  localparam int REF_DUR_SIZE = 4;

  typedef enum logic [2:0] {
    S_INIT_WAIT = 3'd0,
    S_INIT_PRE  = 3'd1,
    S_INIT_REF  = 3'd2,
    S_INIT_LMR  = 3'd3,
    S_IDLE      = 3'd4,
    S_REF       = 3'd5,
    S_RD        = 3'd6,
    S_WR        = 3'd7
  } state_t;

endpackage

`default_nettype wire

// File: rtl/sdram_cmd_issuer_ref_timer.sv
// ============================================================================
// sdram_cmd_issuer_ref_timer : refresh countdown, pending flag, miss counter
// Optional feature macro: SDRAM_REF_MISS_EN (adds saturating ref_miss count)
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module sdram_cmd_issuer_ref_timer #(
  parameter int REF_PERIOD = 1560
) (
  input  logic       clk0,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       clear,
`ifdef SDRAM_REF_MISS_EN
  output logic [7:0] ref_miss,
`endif
  output logic       pending
);

  localparam int CNT_W = (REF_PERIOD > 2) ? $clog2(REF_PERIOD) : 1;
  localparam logic [CNT_W-1:0] LOAD = CNT_W'(REF_PERIOD - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pending_q, pending_d;
  logic             expire;

  always_comb begin
    expire = enable && (cnt_q == '0);
    if (!enable || expire) begin
      cnt_d = LOAD;
    end else begin
      cnt_d = cnt_q - CNT_W'(1);
    end
    // An expiry coinciding with a clear keeps the request alive.
    pending_d = expire | (pending_q & ~clear);
  end

  always_ff @(posedge clk0) begin
    if (!reset_n) begin
      cnt_q     <= '0;
      pending_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
    end
  end

  assign pending = pending_q;

`ifdef SDRAM_REF_MISS_EN
  logic [7:0] miss_q, miss_d;

  always_comb begin
    miss_d = miss_q;
    if (expire && pending_q && !clear && (miss_q != 8'hFF)) begin
      miss_d = miss_q + 8'd1;
    end
  end

  always_ff @(posedge clk0) begin
    if (!reset_n) begin
      miss_q <= 8'd0;
    end else begin
      miss_q <= miss_d;
    end
  end

  assign ref_miss = miss_q;
`endif

endmodule

`default_nettype wire

// File: rtl/sdram_cmd_issuer.sv
// ============================================================================
// sdram_cmd_issuer : SDRAM init sequencer, refresh scheduler and host command
//                    issuer driving held command levels toward the detector
// Optional feature macro: SDRAM_REF_MISS_EN (exposes ref_miss)
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module sdram_cmd_issuer
  import sdram_cmd_issuer_pkg::*;
#(
  parameter int                      INIT_WAIT  = 20000,
  parameter int                      INIT_REFS  = 2,
  parameter int                      REF_PERIOD = 1560,
  parameter logic [REF_DUR_SIZE-1:0] REF_DUR    = 4'b1111
) (
  input  logic                    clk0,
  input  logic                    reset_n,
  input  logic                    host_req,
  input  logic                    host_we,
  output logic                    host_ack,
  input  logic                    do_reada,
  input  logic                    do_writea,
  input  logic                    do_refresh,
  input  logic                    do_preacharge,
  input  logic                    do_load_mod,
  output logic                    nop,
  output logic                    reada,
  output logic                    writea,
  output logic                    refresh,
  output logic                    preacharge,
  output logic                    load_mod,
  output logic                    ref_req,
  output logic [REF_DUR_SIZE-1:0] ref_dur,
`ifdef SDRAM_REF_MISS_EN
  output logic [7:0]              ref_miss,
`endif
  output logic                    init_done
);

  localparam int WAIT_W = (INIT_WAIT > 2) ? $clog2(INIT_WAIT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(INIT_WAIT - 1);
  localparam logic [3:0]        REFS_INIT = 4'(INIT_REFS);

  state_t                  state_q, state_d;
  logic [WAIT_W-1:0]       wait_cnt_q, wait_cnt_d;
  logic [3:0]              iref_cnt_q, iref_cnt_d;
  logic                    nop_q, nop_d;
  logic                    reada_q, reada_d;
  logic                    writea_q, writea_d;
  logic                    refresh_q, refresh_d;
  logic                    pre_q, pre_d;
  logic                    lmr_q, lmr_d;
  logic                    ack_q, ack_d;
  logic                    init_done_q, init_done_d;
  logic [REF_DUR_SIZE-1:0] ref_dur_q;
  logic                    ref_pending;
  logic                    ref_clear;

  assign ref_clear = (state_q == S_REF) && do_refresh;

  sdram_cmd_issuer_ref_timer #(
    .REF_PERIOD (REF_PERIOD)
  ) ref_timer (
    .clk0     (clk0),
    .reset_n  (reset_n),
    .enable   (init_done_q),
    .clear    (ref_clear),
`ifdef SDRAM_REF_MISS_EN
    .ref_miss (ref_miss),
`endif
    .pending  (ref_pending)
  );

  // Outputs are next-state values, so every command level is a flop output.
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    iref_cnt_d  = iref_cnt_q;
    init_done_d = init_done_q;
    nop_d       = 1'b0;
    reada_d     = 1'b0;
    writea_d    = 1'b0;
    refresh_d   = 1'b0;
    pre_d       = 1'b0;
    lmr_d       = 1'b0;
    ack_d       = 1'b0;

    case (state_q)
      S_INIT_WAIT: begin
        if (wait_cnt_q == WAIT_LAST) begin
          state_d = S_INIT_PRE;
          pre_d   = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
          nop_d      = 1'b1;
        end
      end
      S_INIT_PRE: begin
        if (do_preacharge) begin
          state_d    = S_INIT_REF;
          iref_cnt_d = REFS_INIT;
          refresh_d  = 1'b1;
        end else begin
          pre_d = 1'b1;
        end
      end
      S_INIT_REF: begin
        refresh_d = 1'b1;
        if (do_refresh) begin
          iref_cnt_d = iref_cnt_q - 4'd1;
          if (iref_cnt_q == 4'd1) begin
            state_d   = S_INIT_LMR;
            refresh_d = 1'b0;
            lmr_d     = 1'b1;
          end
        end
      end
      S_INIT_LMR: begin
        if (do_load_mod) begin
          state_d     = S_IDLE;
          init_done_d = 1'b1;
        end else begin
          lmr_d = 1'b1;
        end
      end
      S_IDLE: begin
        if (ref_pending) begin
          state_d   = S_REF;
          refresh_d = 1'b1;
        end else if (host_req && init_done_q) begin
          if (host_we) begin
            state_d  = S_WR;
            writea_d = 1'b1;
          end else begin
            state_d = S_RD;
            reada_d = 1'b1;
          end
        end
      end
      S_REF: begin
        if (do_refresh) begin
          state_d = S_IDLE;
        end else begin
          refresh_d = 1'b1;
        end
      end
      S_RD: begin
        if (do_reada) begin
          state_d = S_IDLE;
          ack_d   = 1'b1;
        end else begin
          reada_d = 1'b1;
        end
      end
      S_WR: begin
        if (do_writea) begin
          state_d = S_IDLE;
          ack_d   = 1'b1;
        end else begin
          writea_d = 1'b1;
        end
      end
      default: begin
        state_d = S_INIT_WAIT;
        nop_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk0) begin
    if (!reset_n) begin
      state_q     <= S_INIT_WAIT;
      wait_cnt_q  <= '0;
      iref_cnt_q  <= 4'd0;
      nop_q       <= 1'b1;
      reada_q     <= 1'b0;
      writea_q    <= 1'b0;
      refresh_q   <= 1'b0;
      pre_q       <= 1'b0;
      lmr_q       <= 1'b0;
      ack_q       <= 1'b0;
      init_done_q <= 1'b0;
      ref_dur_q   <= REF_DUR;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      iref_cnt_q  <= iref_cnt_d;
      nop_q       <= nop_d;
      reada_q     <= reada_d;
      writea_q    <= writea_d;
      refresh_q   <= refresh_d;
      pre_q       <= pre_d;
      lmr_q       <= lmr_d;
      ack_q       <= ack_d;
      init_done_q <= init_done_d;
      ref_dur_q   <= REF_DUR;
    end
  end

  assign nop        = nop_q;
  assign reada      = reada_q;
  assign writea     = writea_q;
  assign refresh    = refresh_q;
  assign preacharge = pre_q;
  assign load_mod   = lmr_q;
  assign host_ack   = ack_q;
  assign init_done  = init_done_q;
  assign ref_req    = ref_pending;
  assign ref_dur    = ref_dur_q;

endmodule

`default_nettype wire

// File: tb/tb_sdram_cmd_issuer.sv
// ============================================================================
// tb_sdram_cmd_issuer : directed self-checking bench for sdram_cmd_issuer
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sdram_cmd_issuer;

  logic       clk0 = 1'b0;
  logic       reset_n = 1'b0;
  logic       host_req = 1'b0;
  logic       host_we = 1'b0;
  logic       host_ack;
  logic       do_reada = 1'b0, do_writea = 1'b0, do_refresh = 1'b0;
  logic       do_preacharge = 1'b0, do_load_mod = 1'b0;
  logic       nop, reada, writea, refresh, preacharge, load_mod;
  logic       ref_req, init_done;
  logic [3:0] ref_dur;
`ifdef SDRAM_REF_MISS_EN
  logic [7:0] ref_miss;
`endif

  logic en_pre = 1'b1, en_ref = 1'b1, en_lmr = 1'b1, en_rd = 1'b1, en_wr = 1'b1;
  int   checks = 0;
  int   passed = 0;
  int   failed = 0;
  int   cyc = 0;
  int   ack_cnt = 0;
  int   n, bad, t_done, a0;

  always #5 clk0 = ~clk0;

  sdram_cmd_issuer #(
    .INIT_WAIT  (8),
    .INIT_REFS  (2),
    .REF_PERIOD (40),
    .REF_DUR    (4'b1111)
  ) dut (
    .clk0          (clk0),
    .reset_n       (reset_n),
    .host_req      (host_req),
    .host_we       (host_we),
    .host_ack      (host_ack),
    .do_reada      (do_reada),
    .do_writea     (do_writea),
    .do_refresh    (do_refresh),
    .do_preacharge (do_preacharge),
    .do_load_mod   (do_load_mod),
    .nop           (nop),
    .reada         (reada),
    .writea        (writea),
    .refresh       (refresh),
    .preacharge    (preacharge),
    .load_mod      (load_mod),
    .ref_req       (ref_req),
    .ref_dur       (ref_dur),
`ifdef SDRAM_REF_MISS_EN
    .ref_miss      (ref_miss),
`endif
    .init_done     (init_done)
  );

  // Detector model: one-cycle acknowledge pulse a cycle after a command level.
  always @(posedge clk0) begin
    do_preacharge <= en_pre & preacharge & ~do_preacharge;
    do_refresh    <= en_ref & refresh    & ~do_refresh;
    do_load_mod   <= en_lmr & load_mod   & ~do_load_mod;
    do_reada      <= en_rd  & reada      & ~do_reada;
    do_writea     <= en_wr  & writea     & ~do_writea;
    cyc           <= cyc + 1;
    if (host_ack === 1'b1) ack_cnt <= ack_cnt + 1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk0);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Entered on the first negedge after the last reset edge.
  task automatic init_sequence(input string tag);
    n = 0;
    while (nop === 1'b1 && n < 100) begin n++; tick(); end
    check({tag, "_nop_cycles"}, n, 8);
    check({tag, "_pre_start"}, {nop, preacharge}, 2'b01);
    n = 0;
    while (preacharge === 1'b1 && n < 20) begin n++; tick(); end
    check({tag, "_pre_cycles"}, n, 2);
    check({tag, "_ref_start"}, refresh, 1'b1);
    n = 0;
    while (refresh === 1'b1 && n < 20) begin n++; tick(); end
    check({tag, "_ref_cycles"}, n, 4);
    check({tag, "_lmr_start"}, load_mod, 1'b1);
    n = 0; bad = 0;
    while (load_mod === 1'b1 && n < 20) begin
      if (init_done !== 1'b0) bad++;
      n++; tick();
    end
    check({tag, "_lmr_cycles"}, n, 2);
    check({tag, "_early_done"}, bad, 0);
    check({tag, "_done"}, {init_done, load_mod, nop}, 3'b100);
  endtask

  initial begin
    repeat (3) tick();
    check("rst_nop", nop, 1'b1);
    check("rst_cmds", {preacharge, refresh, load_mod, reada, writea}, 5'b00000);
    check("rst_flags", {ref_req, host_ack, init_done}, 3'b000);
    check("rst_ref_dur", ref_dur, 4'hF);
`ifdef SDRAM_REF_MISS_EN
    check("rst_miss", ref_miss, 8'd0);
`endif
    reset_n = 1'b1;
    init_sequence("init");
    t_done = cyc;

    // Plain read from idle
    host_req = 1'b1; host_we = 1'b0;
    tick(); check("rd_level", {reada, writea}, 2'b10);
    tick(); check("rd_hold", {reada, host_ack}, 2'b10);
    tick(); check("rd_ack", {reada, host_ack, writea}, 3'b010);
    host_req = 1'b0;
    tick(); check("rd_ack_single", {host_ack, reada}, 2'b00);

    // Refresh period and priority over a simultaneous write request
    n = 0;
    while (ref_req !== 1'b1 && n < 200) begin n++; tick(); end
    check("ref_period", cyc - t_done, 40);
    host_req = 1'b1; host_we = 1'b1;
    tick(); check("ref_prio", {refresh, writea}, 2'b10);
    tick(); check("ref_hold", {refresh, writea}, 2'b10);
    tick(); check("ref_done", {refresh, writea, ref_req}, 3'b000);
    tick(); check("wr_after_ref", writea, 1'b1);
    n = 0;
    while (host_ack !== 1'b1 && n < 20) begin n++; tick(); end
    check("wr_ack", {host_ack, writea}, 2'b10);
    host_req = 1'b0;
    en_ref = 1'b0;

    // Withheld refresh acknowledge
    n = 0;
    while (ref_req !== 1'b1 && n < 100) begin n++; tick(); end
    check("ref2_req", ref_req, 1'b1);
    tick();
    bad = 0;
    repeat (100) begin
      if (ref_req !== 1'b1 || refresh !== 1'b1) bad++;
      tick();
    end
    check("ref_held", bad, 0);
`ifdef SDRAM_REF_MISS_EN
    check("ref_miss", ref_miss, 8'd2);
`endif
    en_ref = 1'b1;
    n = 0;
    while (refresh === 1'b1 && n < 10) begin n++; tick(); end
    check("ref_release", {refresh, ref_req}, 2'b00);

    // Withheld read acknowledge
    en_rd = 1'b0; a0 = ack_cnt;
    host_req = 1'b1; host_we = 1'b0;
    n = 0;
    while (reada !== 1'b1 && n < 20) begin n++; tick(); end
    check("rd2_level", reada, 1'b1);
    bad = 0;
    repeat (10) begin
      tick();
      if (reada !== 1'b1 || host_ack !== 1'b0) bad++;
    end
    check("rd_withheld", bad, 0);
    en_rd = 1'b1;
    n = 0;
    while (host_ack !== 1'b1 && n < 10) begin n++; tick(); end
    host_req = 1'b0;
    check("rd2_ack", host_ack, 1'b1);
    repeat (3) tick();
    check("rd_ack_once", ack_cnt - a0, 1);

    // Reset while a write is held
    en_wr = 1'b0; a0 = ack_cnt;
    host_req = 1'b1; host_we = 1'b1;
    n = 0;
    while (writea !== 1'b1 && n < 30) begin n++; tick(); end
    check("wr_entered", writea, 1'b1);
    reset_n = 1'b0;
    tick();
    check("rst_wr", {writea, init_done, nop, host_ack}, 4'b0010);
`ifdef SDRAM_REF_MISS_EN
    check("rst_wr_miss", ref_miss, 8'd0);
`endif
    host_req = 1'b0; en_wr = 1'b1;
    reset_n = 1'b1;
    init_sequence("reinit");
    repeat (2) tick();
    check("rst_no_ack", ack_cnt - a0, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sdram_cmd_issuer.md
# sdram_cmd_issuer

The SDRAM command issuer sits on the processor side of the SDRAM controller and drives the `cmd_detector` command lines. It runs the power-up initialisation sequence and generates periodic refresh requests. It also converts processor read and write requests into held command levels. Each level stays asserted until the matching `do_*` acknowledge returns from the detector.

## Interface
Parameters:
- `INIT_WAIT`, default 20000: power-up NOP cycles (200 µs at 100 MHz).
- `INIT_REFS`, default 2: number of auto-refreshes during init, valid range 1..15.
- `REF_PERIOD`, default 1560: cycles between refresh requests, must be ≥ 16.
- `REF_DUR`, default 4'b1111: value driven on `ref_dur`.

Ports:
- `clk0`  in  1  sole clock.
- `reset_n`  in  1  synchronous, active-low reset.
- `host_req`  in  1  processor access request, held until `host_ack`.
- `host_we`  in  1  1 = write, 0 = read; valid while `host_req` is high.
- `host_ack`  out  1  one-cycle pulse: access command accepted.
- `do_reada`, `do_writea`, `do_refresh`, `do_preacharge`, `do_load_mod`  in  1 each  acknowledges from the detector.
- `nop`, `reada`, `writea`, `refresh`, `preacharge`, `load_mod`  out  1 each  command levels.
- `ref_req`  out  1  refresh pending.
- `ref_dur`  out  `ref_dur_size`  refresh duration to the detector.
- `init_done`  out  1  initialisation complete.
- `ref_miss`  out  8  saturating missed-refresh count; present only under `SDRAM_REF_MISS_EN`.

## Operation
- All outputs are registered. Clock edges that sample `reset_n`=0 load reset values:
  - state = S_INIT_WAIT, `nop`=1.
  - All other command lines, `ref_req`, `host_ack` and `init_done` = 0.
  - `ref_dur`=`REF_DUR`, `ref_miss`=0.
  - Counters are cleared.
- Reset mid-operation abandons any held command at once. There is no completion and no `host_ack`.
- FSM states:
  - S_INIT_WAIT: `nop`=1 for exactly `INIT_WAIT` cycles, then go to S_INIT_PRE.
  - S_INIT_PRE: hold `preacharge`=1 until `do_preacharge`, then go to S_INIT_REF.
  - S_INIT_REF: hold `refresh`=1 until `do_refresh`, decrement the init-refresh count, and repeat until `INIT_REFS` acknowledges are seen, then go to S_INIT_LMR.
  - S_INIT_LMR: hold `load_mod`=1 until `do_load_mod`, then set `init_done`=1 and go to S_IDLE.
  - S_IDLE: all command lines 0.
    - If the refresh is pending, go to S_REF. This is checked first.
    - Otherwise, if `host_req` is high, go to S_WR when `host_we`=1 or S_RD when `host_we`=0.
  - S_REF: hold `refresh`=1 until `do_refresh`, then go to S_IDLE.
  - S_RD / S_WR: hold `reada` / `writea`=1 until `do_reada` / `do_writea`. On that cycle, pulse `host_ack` and return to S_IDLE.
- Refresh timer:
  - It is idle until `init_done`, then counts down from `REF_PERIOD`-1.
  - On reaching 0 it sets the pending flag and reloads.
  - `ref_req` equals the pending flag.
  - The flag clears on a `do_refresh` seen in S_REF.
  - If the timer expires on the same cycle the flag clears, the flag stays set.
- `host_req` is ignored while `init_done`=0.
- A `do_*` that does not match the current state is ignored.

## Timing
- On the edge entering S_RD at cycle N, `reada` rises.
- The detector raises `do_reada` at N+1.
- At N+2 the issuer samples `do_reada`: `reada` falls and `host_ack` is high for cycle N+2 only.
- The FSM is back in S_IDLE at N+2. The earliest next command level is at N+3.
- Write and refresh commands follow the same timing.
- Host-request latency from S_IDLE with no refresh pending is 1 cycle to the command level.
- Refresh priority: a pending refresh pre-empts a `host_req` that arrives in the same cycle.

## Configuration
- `SDRAM_REF_MISS_EN` defined:
  - `ref_miss` exists.
  - It increments, saturating at 255, when the timer expires while the flag is already set and not clearing in the same cycle.
- Not defined: the port and counter are absent, and a second expiry merges into the single pending flag.

## Structure
- The state encodings and the `ref_dur_size` width belong in the shared `parameter.v` include.
- One sub-module, `ref_timer`, holds the countdown, the pending flag and the miss counter. Its ports are `clk0`, `reset_n`, `enable`, `clear`, `pending`, and `ref_miss`.

## Test plan
All scenarios use `INIT_WAIT`=8, `INIT_REFS`=2, `REF_PERIOD`=40 unless stated.
- Reset release, with each `do_*` echoed 1 cycle after its command:
  - `nop`=1 for 8 cycles, then `preacharge`, `refresh` ×2, `load_mod`, each held until echoed.
  - `init_done`=1 after the `do_load_mod` edge.
- After init, `host_req`=1 with `host_we`=0:
  - `reada` is high for 2 cycles.
  - `host_ack` is one pulse on the cycle after `do_reada`.
  - `writea` stays 0.
- Refresh timer:
  - `ref_req` rises 40 cycles after `init_done`.
  - A `host_req` in the same cycle waits until `do_refresh`, then `writea` follows.
- Withhold `do_refresh` for 100 cycles:
  - `ref_req` stays 1 and `refresh` stays held.
  - With the macro defined, `ref_miss`=2.
- Drop `reset_n` mid-S_WR:
  - The next cycle shows `writea`=0, `init_done`=0 and `nop`=1.
  - There is no `host_ack`, and the init sequence restarts.
- Withhold `do_reada` for 10 cycles:
  - `reada` stays held and `host_ack` stays 0.
  - Releasing it produces exactly one `host_ack`.
